// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the addu/subu/ori/lw/sw/beq datapath: sequences
// FETCH/DECODE/EXEC/MEM/WB, drives ALU op and datapath enables, counts retirements.
module mc_ctrl_fsm #(
   parameter int RETIRE_W     = 32,
   parameter bit ILLEGAL_HALT = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic [2:0]          alu_ctrl,
   output logic                alu_src_b,
   output logic                ext_zero,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                ir_wr,
   output logic                pc_wr,
   output logic                pc_branch,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                reg_wr,
   output logic [2:0]          state,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ILL  = 3'd0,
      C_ADDU = 3'd1,
      C_SUBU = 3'd2,
      C_ORI  = 3'd3,
      C_LW   = 3'd4,
      C_SW   = 3'd5,
      C_BEQ  = 3'd6
   } class_t;

   state_t              r_state;
   state_t              w_next;
   class_t              r_class;
   class_t              w_dec_class;
   logic                r_illegal;
   logic [RETIRE_W-1:0] r_retired;
   logic                w_retire;
   logic [2:0]          w_class_alu;

   // Memory handshake: an access held on mem_rd/mem_wr completes in the cycle
   // mem_ready is high; mem_ready is ignored outside FETCH and MEM.
   always_comb begin
      w_dec_class = C_ILL;
      case (op)
         6'b000000: begin
            if (funct == 6'b100001)      w_dec_class = C_ADDU;
            else if (funct == 6'b100011) w_dec_class = C_SUBU;
         end
         6'b001101: w_dec_class = C_ORI;
         6'b100011: w_dec_class = C_LW;
         6'b101011: w_dec_class = C_SW;
         6'b000100: w_dec_class = C_BEQ;
         default:   w_dec_class = C_ILL;
      endcase
   end

   always_comb begin
      w_class_alu = 3'b000;
      case (r_class)
         C_ADDU:  w_class_alu = 3'b001;
         C_SUBU:  w_class_alu = 3'b011;
         C_ORI:   w_class_alu = 3'b010;
         C_LW:    w_class_alu = 3'b110;
         C_SW:    w_class_alu = 3'b111;
         C_BEQ:   w_class_alu = 3'b101;
         default: w_class_alu = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_class   <= C_ILL;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_class <= w_dec_class;
            if (w_dec_class == C_ILL) r_illegal <= 1'b1;
         end
         if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
      end
   end

   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      alu_ctrl   = 3'b000;
      alu_src_b  = 1'b0;
      ext_zero   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      pc_branch  = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_wr  = 1'b1;
               pc_wr  = 1'b1;
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_dec_class == C_ILL) w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
            else                      w_next = S_EXEC;
         end
         S_EXEC: begin
            alu_ctrl  = w_class_alu;
            alu_src_b = (r_class == C_ORI) || (r_class == C_LW) || (r_class == C_SW);
            ext_zero  = (r_class == C_ORI);
            case (r_class)
               C_ADDU, C_SUBU, C_ORI: w_next = S_WB;
               C_LW, C_SW:            w_next = S_MEM;
               C_BEQ: begin
                  pc_wr     = zero;
                  pc_branch = zero;
                  w_retire  = 1'b1;
                  w_next    = S_FETCH;
               end
               default:               w_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            // ALU op held so the address presented to memory is stable across stalls
            alu_ctrl = w_class_alu;
            mem_rd   = (r_class == C_LW);
            mem_wr   = (r_class == C_SW);
            if (mem_ready) begin
               w_retire = (r_class == C_SW);
               w_next   = (r_class == C_LW) ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            reg_wr     = 1'b1;
            reg_dst    = (r_class == C_ADDU) || (r_class == C_SUBU);
            mem_to_reg = (r_class == C_LW);
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
      if (rst) begin
         w_retire   = 1'b0;
         alu_ctrl   = 3'b000;
         alu_src_b  = 1'b0;
         ext_zero   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         ir_wr      = 1'b0;
         pc_wr      = 1'b0;
         pc_branch  = 1'b0;
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         reg_wr     = 1'b0;
      end
   end

   assign state   = r_state;
   assign illegal = r_illegal;
   assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: two instances (refetch and halt on illegal) driven with the
// same randomized instruction stream, each cycle compared against a phase-table model.
module tb_mc_ctrl_fsm;

   localparam int RW = 4;
   localparam int EW = 21;
   localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_ILL = 6;
   localparam logic [9:0] SRCB = 10'b10_0000_0000;
   localparam logic [9:0] EXTZ = 10'b01_0000_0000;
   localparam logic [9:0] RDST = 10'b00_1000_0000;
   localparam logic [9:0] M2R  = 10'b00_0100_0000;
   localparam logic [9:0] IRWR = 10'b00_0010_0000;
   localparam logic [9:0] PCWR = 10'b00_0001_0000;
   localparam logic [9:0] PCBR = 10'b00_0000_1000;
   localparam logic [9:0] MRD  = 10'b00_0000_0100;
   localparam logic [9:0] MWR  = 10'b00_0000_0010;
   localparam logic [9:0] RWR  = 10'b00_0000_0001;

   logic clk = 1'b0;
   logic rst, zero, mem_ready;
   logic [5:0] op, funct;

   logic [2:0] d1_alu_ctrl, d1_state, d2_alu_ctrl, d2_state;
   logic d1_alu_src_b, d1_ext_zero, d1_reg_dst, d1_mem_to_reg, d1_ir_wr, d1_pc_wr;
   logic d1_pc_branch, d1_mem_rd, d1_mem_wr, d1_reg_wr, d1_illegal;
   logic d2_alu_src_b, d2_ext_zero, d2_reg_dst, d2_mem_to_reg, d2_ir_wr, d2_pc_wr;
   logic d2_pc_branch, d2_mem_rd, d2_mem_wr, d2_reg_wr, d2_illegal;
   logic [RW-1:0] d1_retired, d2_retired;
   logic [EW-1:0] act1, act2, e1, e2;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp2_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int   m_ret, m_ret2;
   logic m_ill, halted2;

   // per-instruction cycle plan
   logic [2:0] p_st[16];
   logic [2:0] p_alu[16];
   logic [9:0] p_en[16];
   logic       p_mr[16], p_z[16], p_dec[16], p_ret[16], p_ill[16];
   int         p_n;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.RETIRE_W(RW), .ILLEGAL_HALT(1'b0)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .alu_ctrl(d1_alu_ctrl), .alu_src_b(d1_alu_src_b), .ext_zero(d1_ext_zero),
      .reg_dst(d1_reg_dst), .mem_to_reg(d1_mem_to_reg), .ir_wr(d1_ir_wr), .pc_wr(d1_pc_wr),
      .pc_branch(d1_pc_branch), .mem_rd(d1_mem_rd), .mem_wr(d1_mem_wr), .reg_wr(d1_reg_wr),
      .state(d1_state), .illegal(d1_illegal), .retired(d1_retired));

   mc_ctrl_fsm #(.RETIRE_W(RW), .ILLEGAL_HALT(1'b1)) dut_halt (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .alu_ctrl(d2_alu_ctrl), .alu_src_b(d2_alu_src_b), .ext_zero(d2_ext_zero),
      .reg_dst(d2_reg_dst), .mem_to_reg(d2_mem_to_reg), .ir_wr(d2_ir_wr), .pc_wr(d2_pc_wr),
      .pc_branch(d2_pc_branch), .mem_rd(d2_mem_rd), .mem_wr(d2_mem_wr), .reg_wr(d2_reg_wr),
      .state(d2_state), .illegal(d2_illegal), .retired(d2_retired));

   assign act1 = {d1_state, d1_alu_ctrl, d1_alu_src_b, d1_ext_zero, d1_reg_dst, d1_mem_to_reg,
                  d1_ir_wr, d1_pc_wr, d1_pc_branch, d1_mem_rd, d1_mem_wr, d1_reg_wr,
                  d1_illegal, d1_retired};
   assign act2 = {d2_state, d2_alu_ctrl, d2_alu_src_b, d2_ext_zero, d2_reg_dst, d2_mem_to_reg,
                  d2_ir_wr, d2_pc_wr, d2_pc_branch, d2_mem_rd, d2_mem_wr, d2_reg_wr,
                  d2_illegal, d2_retired};

   // monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         e1 = exp_q.pop_front();
         n_checks++;
         if (act1 !== e1) begin
            n_fail++;
            $display("FAIL cycle_refetch t=%0t actual st=%0d alu=%b en=%b ill=%b ret=%0d required st=%0d alu=%b en=%b ill=%b ret=%0d",
                     $time, act1[20:18], act1[17:15], act1[14:5], act1[4], act1[3:0],
                     e1[20:18], e1[17:15], e1[14:5], e1[4], e1[3:0]);
         end
      end
      if (exp2_q.size() != 0) begin
         e2 = exp2_q.pop_front();
         n_checks++;
         if (act2 !== e2) begin
            n_fail++;
            $display("FAIL cycle_halt t=%0t actual st=%0d alu=%b en=%b ill=%b ret=%0d required st=%0d alu=%b en=%b ill=%b ret=%0d",
                     $time, act2[20:18], act2[17:15], act2[14:5], act2[4], act2[3:0],
                     e2[20:18], e2[17:15], e2[14:5], e2[4], e2[3:0]);
         end
      end
   end

   function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
      return (o == 6'b000000 && (f == 6'b100001 || f == 6'b100011)) || o == 6'b001101 ||
             o == 6'b100011 || o == 6'b101011 || o == 6'b000100;
   endfunction

   task automatic pick_code(input int kind, output logic [5:0] o, output logic [5:0] f);
      f = 6'($urandom);
      case (kind)
         K_ADDU: begin o = 6'b000000; f = 6'b100001; end
         K_SUBU: begin o = 6'b000000; f = 6'b100011; end
         K_ORI:  o = 6'b001101;
         K_LW:   o = 6'b100011;
         K_SW:   o = 6'b101011;
         K_BEQ:  o = 6'b000100;
         default: begin
            if ($urandom_range(0, 1) == 0) o = 6'b000000;
            else o = 6'($urandom);
            while (is_legal(o, f)) begin
               o = 6'($urandom);
               f = 6'($urandom);
            end
         end
      endcase
   endtask

   task automatic drive_cycle(input logic rst_v, input logic [2:0] st, input logic [2:0] alu,
                              input logic [9:0] en, input logic mr, input logic zv,
                              input logic dec, input logic [5:0] op_v, input logic [5:0] funct_v);
      rst       = rst_v;
      mem_ready = mr;
      zero      = zv;
      op        = dec ? op_v : 6'($urandom);
      funct     = dec ? funct_v : 6'($urandom);
      exp_q.push_back({st, alu, en, m_ill, 4'(m_ret)});
      if (halted2) exp2_q.push_back({3'd5, 3'd0, 10'd0, 1'b1, 4'(m_ret2)});
      else         exp2_q.push_back({st, alu, en, m_ill, 4'(m_ret2)});
      @(posedge clk);
      #1;
   endtask

   task automatic reset_cycle(input logic [2:0] st);
      drive_cycle(1'b1, st, 3'd0, 10'd0, 1'($urandom), 1'($urandom), 1'b0, 6'd0, 6'd0);
      m_ret   = 0;
      m_ret2  = 0;
      m_ill   = 1'b0;
      halted2 = 1'b0;
   endtask

   task automatic add_cyc(input logic [2:0] st, input logic [2:0] alu, input logic [9:0] en,
                          input logic mr, input logic zv, input logic dec,
                          input logic ret, input logic ill);
      p_st[p_n]  = st;
      p_alu[p_n] = alu;
      p_en[p_n]  = en;
      p_mr[p_n]  = mr;
      p_z[p_n]   = zv;
      p_dec[p_n] = dec;
      p_ret[p_n] = ret;
      p_ill[p_n] = ill;
      p_n++;
   endtask

   // fs/ms: cycles of mem_ready=0 in FETCH/MEM; abort_sel >= 0 asserts rst on that plan cycle
   task automatic play_instr(input int kind, input logic [5:0] o, input logic [5:0] f,
                             input int fs, input int ms, input logic zv, input int abort_sel);
      logic [2:0] alu;
      logic [9:0] en;
      int ab;
      p_n = 0;
      case (kind)
         K_ADDU:  alu = 3'b001;
         K_SUBU:  alu = 3'b011;
         K_ORI:   alu = 3'b010;
         K_LW:    alu = 3'b110;
         K_SW:    alu = 3'b111;
         K_BEQ:   alu = 3'b101;
         default: alu = 3'b000;
      endcase
      for (int i = 0; i < fs; i++) add_cyc(3'd0, 3'd0, MRD, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
      add_cyc(3'd0, 3'd0, MRD | IRWR | PCWR, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
      add_cyc(3'd1, 3'd0, 10'd0, 1'($urandom), 1'($urandom), 1'b1, 1'b0, kind == K_ILL);
      if (kind != K_ILL) begin
         en = 10'd0;
         if (kind == K_ORI || kind == K_LW || kind == K_SW) en = en | SRCB;
         if (kind == K_ORI) en = en | EXTZ;
         if (kind == K_BEQ) begin
            if (zv) en = PCWR | PCBR;
            add_cyc(3'd2, alu, en, 1'($urandom), zv, 1'b0, 1'b1, 1'b0);
         end else begin
            add_cyc(3'd2, alu, en, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
         end
         if (kind == K_LW || kind == K_SW) begin
            en = (kind == K_LW) ? MRD : MWR;
            for (int i = 0; i < ms; i++) add_cyc(3'd3, alu, en, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
            add_cyc(3'd3, alu, en, 1'b1, 1'($urandom), 1'b0, kind == K_SW, 1'b0);
         end
         if (kind == K_ADDU || kind == K_SUBU) add_cyc(3'd4, 3'd0, RWR | RDST, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
         if (kind == K_ORI) add_cyc(3'd4, 3'd0, RWR, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
         if (kind == K_LW)  add_cyc(3'd4, 3'd0, RWR | M2R, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
      end
      ab = (abort_sel < 0) ? -1 : (abort_sel % p_n);
      for (int c = 0; c < p_n; c++) begin
         if (c == ab) begin
            reset_cycle(p_st[c]);
            return;
         end
         drive_cycle(1'b0, p_st[c], p_alu[c], p_en[c], p_mr[c], p_z[c], p_dec[c], o, f);
         if (p_ret[c]) begin
            m_ret++;
            if (!halted2) m_ret2++;
         end
         if (p_ill[c]) begin
            m_ill   = 1'b1;
            halted2 = 1'b1;
         end
      end
   endtask

   task automatic play_kind(input int kind, input int fs, input int ms, input logic zv);
      logic [5:0] o, f;
      pick_code(kind, o, f);
      play_instr(kind, o, f, fs, ms, zv, -1);
   endtask

   initial begin
      logic [5:0] o, f;
      int kind, fs, ms, ab;
      rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      m_ret = 0; m_ret2 = 0; m_ill = 1'b0; halted2 = 1'b0;
      @(posedge clk);
      #1;
      reset_cycle(3'd0);

      play_kind(K_ADDU, 0, 0, 1'b0);
      play_kind(K_LW, 0, 3, 1'b0);
      play_kind(K_BEQ, 0, 0, 1'b1);
      play_kind(K_BEQ, 0, 0, 1'b0);
      play_kind(K_SUBU, 2, 0, 1'b0);
      play_kind(K_SW, 1, 2, 1'b0);
      play_instr(K_ILL, 6'b111111, 6'($urandom), 0, 0, 1'b0, -1);
      play_kind(K_ORI, 0, 0, 1'b0);
      play_kind(K_LW, 1, 1, 1'b0);
      play_kind(K_BEQ, 0, 0, 1'b1);
      reset_cycle(3'd0);

      pick_code(K_SW, o, f);
      play_instr(K_SW, o, f, 0, 3, 1'b0, 4);

      for (int i = 0; i < 17; i++) play_kind(K_ORI, 0, 0, 1'b0);
      play_kind(K_ADDU, 0, 0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 6);
         fs = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 15) : -1;
         pick_code(kind, o, f);
         play_instr(kind, o, f, fs, ms, 1'($urandom), ab);
         if ($urandom_range(0, 24) == 0) reset_cycle(3'd0);
      end

      @(negedge clk);
      if (exp_q.size() != 0 || exp2_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain actual=%0d/%0d entries left required=0/0", exp_q.size(), exp2_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
